packetizer_arbiter: RTL and testbench
=====================================

PACKETIZER_ARBITER -- requirements
Module: packetizer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL be the number of requesters sharing one packetizer_sop input port (2..8).
REQ-002 Parameter ADDRESS_WIDTH, default 4, SHALL be the NoC destination width.
REQ-003 Parameter WIDTH_IN, default 12, SHALL be the data word width per requester.
REQ-004 Clocking and reset SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be as follows (clock and reset first):
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- r_data_in  in  NUM_REQ*WIDTH_IN  per-requester data word; requester i occupies slice i.
- r_valid_in  in  NUM_REQ*4  per-requester flit-valid bits.
- r_sop_in  in  NUM_REQ*4  per-requester flit start-of-packet bits.
- r_eop_in  in  NUM_REQ*4  per-requester flit end-of-packet bits.
- r_dest_in  in  NUM_REQ*ADDRESS_WIDTH  per-requester destination.
- r_ready_out  out  NUM_REQ  word accepted from requester i this cycle.
- p_data_out  out  WIDTH_IN  word to packetizer.
- p_valid_out  out  4  flit-valid bits to packetizer.
- p_sop_out  out  4  sop bits to packetizer.
- p_eop_out  out  4  eop bits to packetizer.
- p_dest_out  out  ADDRESS_WIDTH  destination to packetizer.
- p_ready_in  in  1  packetizer ready.
- o_locked  out  1  a packet is open and the grant is held.
- o_owner  out  clog2(NUM_REQ)  current or last granted requester.

Function
REQ-006 Requester i SHALL be "active" when any bit of its r_valid_in slice is 1.
REQ-007 The output SHALL be a single register stage; the word is "pending" when any p_valid_out bit is 1.
REQ-008 The output stage SHALL load when it is empty or when p_ready_in=1; "load" means the output stage may accept a word this cycle.
REQ-009 Transfer rules:
- r_ready_out[g] SHALL be 1 only for the granted requester g, and only when load=1 and g is active.
- All other r_ready_out bits SHALL be 0.
- A word transfers when r_ready_out[g]=1.
- Latency SHALL be 1 cycle: the transferred word appears on p_* the next cycle.
REQ-010 On load with no transfer, p_valid_out SHALL become 4'b0000; the other p_* fields are don't-care.
REQ-011 The FSM SHALL have two states, IDLE and LOCKED.
REQ-012 In IDLE, g SHALL be the first active requester searching round-robin from (ptr+1) mod NUM_REQ.
REQ-013 In LOCKED, g SHALL equal o_owner whether or not that requester is active; no other requester is served.
REQ-014 Open-packet evaluation on each transfer:
- Start with open = (state==LOCKED).
- For flit k=0..3 with valid[k]=1, apply in order: if sop[k] then open=1; if eop[k] then open=0.
- Flits with valid[k]=0 are ignored.
REQ-015 After a transfer:
- If open=1, the next state SHALL be LOCKED and o_owner SHALL be g.
- If open=0, the next state SHALL be IDLE, ptr SHALL be g, and o_owner SHALL be g.
REQ-016 A sop-and-eop in the same flit SHALL leave open=0; an eop without a preceding sop SHALL be passed through unchanged and leave open=0.
REQ-017 A second sop while open SHALL keep the block LOCKED; no error is flagged.
REQ-018 o_locked SHALL equal (state==LOCKED).
REQ-019 When p_ready_in=0 with a pending word, the p_* outputs SHALL hold stable and r_ready_out SHALL be all zero.

Reset
REQ-020 When rst_n=0, the following SHALL hold asynchronously:
- p_valid_out=0, p_sop_out=0, p_eop_out=0, p_data_out=0, p_dest_out=0.
- State IDLE, ptr=NUM_REQ-1, o_owner=0, o_locked=0, r_ready_out=0.
REQ-021 A reset asserted mid-packet SHALL discard the open packet and the pending word; after release, arbitration SHALL restart with requester 0 at highest priority.

Verification
REQ-022 Reset then all 4 requesters active with single-word packets (valid=1111, sop=1000, eop=0001), p_ready_in=1 -> grants 0,1,2,3,0 on consecutive cycles; o_locked stays 0.
REQ-023 Requester 1 sends a 3-word packet (word 1 sop=0001; word 2 no sop/eop; word 3 eop=1000) while requester 2 is active throughout -> requester 2 receives no r_ready_out until the cycle after the eop word transfers; o_locked=1 for exactly 2 cycles.
REQ-024 LOCKED to requester 0 while requester 0 deasserts valid for 5 cycles and requester 3 is active -> r_ready_out=0000 for all 5 cycles, then requester 0 resumes.
REQ-025 p_ready_in=0 for 3 cycles with a pending word -> p_* outputs stable, r_ready_out=0; on p_ready_in=1, the next word loads in the same cycle.
REQ-026 Word with valid=1111, sop=0101, eop=0010 -> open=1, LOCKED; the following word with eop=0001 -> IDLE, ptr=owner.
REQ-027 rst_n pulsed low while LOCKED to requester 2 -> p_valid_out=0 immediately; after release, requester 0 is granted first when active.

Source files
------------

// File: rtl/packetizer_arbiter.sv
// Round-robin arbiter that feeds one packetizer port from NUM_REQ requesters.
// Once a packet is open, the grant stays with its owner until the packet closes.
module packetizer_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDRESS_WIDTH = 4,
    parameter int WIDTH_IN      = 12,
    localparam int OW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ*WIDTH_IN-1:0]       r_data_in,
    input  logic [NUM_REQ*4-1:0]              r_valid_in,
    input  logic [NUM_REQ*4-1:0]              r_sop_in,
    input  logic [NUM_REQ*4-1:0]              r_eop_in,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  r_dest_in,
    output logic [NUM_REQ-1:0]                r_ready_out,
    output logic [WIDTH_IN-1:0]               p_data_out,
    output logic [3:0]                        p_valid_out,
    output logic [3:0]                        p_sop_out,
    output logic [3:0]                        p_eop_out,
    output logic [ADDRESS_WIDTH-1:0]          p_dest_out,
    input  logic                              p_ready_in,
    output logic                              o_locked,
    output logic [OW-1:0]                     o_owner
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                     r_state, w_state_nxt;
    logic [OW-1:0]              r_ptr, w_ptr_nxt;
    logic [OW-1:0]              r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0]         w_active;
    logic                       w_rr_found;
    logic [OW-1:0]              w_rr_idx;
    logic [OW-1:0]              w_grant;
    logic                       w_grant_active;
    logic                       w_load;
    logic                       w_xfer;
    logic                       w_open;
    logic [WIDTH_IN-1:0]        w_sel_data;
    logic [3:0]                 w_sel_valid;
    logic [3:0]                 w_sel_sop;
    logic [3:0]                 w_sel_eop;
    logic [ADDRESS_WIDTH-1:0]   w_sel_dest;

    // Flit 0 is the most significant bit; sop opens, eop closes, in flit order.
    function automatic logic open_after(input logic open_in, input logic [3:0] v,
                                        input logic [3:0] s, input logic [3:0] e);
        logic o;
        o = open_in;
        for (int k = 0; k < 4; k++) begin
            if (v[3-k]) begin
                if (s[3-k]) o = 1'b1;
                else        o = o;
                if (e[3-k]) o = 1'b0;
                else        o = o;
            end else begin
                o = o;
            end
        end
        return o;
    endfunction

    // Round-robin search from the requester after ptr, plus grant muxing.
    always_comb begin
        int            c;
        logic [OW-1:0] c_idx;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(r_ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            else              c = c;
            c_idx = OW'(c);
            if (!w_rr_found && w_active[c_idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = c_idx;
            end else begin
                w_rr_found = w_rr_found;
            end
        end
        w_grant        = (r_state == ST_LOCKED) ? r_owner : w_rr_idx;
        w_sel_data     = '0;
        w_sel_valid    = 4'b0000;
        w_sel_sop      = 4'b0000;
        w_sel_eop      = 4'b0000;
        w_sel_dest     = '0;
        w_grant_active = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == OW'(i)) begin
                w_sel_data     = r_data_in[i*WIDTH_IN +: WIDTH_IN];
                w_sel_valid    = r_valid_in[i*4 +: 4];
                w_sel_sop      = r_sop_in[i*4 +: 4];
                w_sel_eop      = r_eop_in[i*4 +: 4];
                w_sel_dest     = r_dest_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_grant_active = w_active[i];
            end else begin
                w_grant_active = w_grant_active;
            end
        end
    end

    // Per-requester activity and transfer qualification.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_active[i] = |r_valid_in[i*4 +: 4];
        end
        w_load = (p_valid_out == 4'b0000) || p_ready_in;
        w_xfer = rst_n && w_load &&
                 ((r_state == ST_LOCKED) ? w_grant_active : w_rr_found);
        w_open = open_after(r_state == ST_LOCKED, w_sel_valid, w_sel_sop, w_sel_eop);
    end

    // State register with arbitration pointer and owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= OW'(NUM_REQ - 1);
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state: the pointer only moves when a packet closes.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_xfer) begin
            w_owner_nxt = w_grant;
            case (w_open)
                1'b1:    w_state_nxt = ST_LOCKED;
                1'b0: begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = w_grant;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Outputs decoded from state and the current transfer.
    always_comb begin
        o_locked    = (r_state == ST_LOCKED);
        o_owner     = r_owner;
        r_ready_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            r_ready_out[i] = w_xfer && (w_grant == OW'(i));
        end
    end

    // Single output register stage toward the packetizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_out  <= '0;
            p_valid_out <= 4'b0000;
            p_sop_out   <= 4'b0000;
            p_eop_out   <= 4'b0000;
            p_dest_out  <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                p_data_out  <= w_sel_data;
                p_valid_out <= w_sel_valid;
                p_sop_out   <= w_sel_sop;
                p_eop_out   <= w_sel_eop;
                p_dest_out  <= w_sel_dest;
            end else begin
                p_valid_out <= 4'b0000;
                p_sop_out   <= 4'b0000;
                p_eop_out   <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_packetizer_arbiter.sv
// Bench for packetizer_arbiter: directed scenarios with literal expectations,
// then random traffic checked each cycle against a behavioural model.
module tb_packetizer_arbiter;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int W  = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*W-1:0]    r_data_in;
    logic [N*4-1:0]    r_valid_in, r_sop_in, r_eop_in;
    logic [N*AW-1:0]   r_dest_in;
    logic [N-1:0]      r_ready_out;
    logic [W-1:0]      p_data_out;
    logic [3:0]        p_valid_out, p_sop_out, p_eop_out;
    logic [AW-1:0]     p_dest_out;
    logic              p_ready_in;
    logic              o_locked;
    logic [1:0]        o_owner;

    int checks   = 0;
    int failures = 0;

    packetizer_arbiter #(.NUM_REQ(N), .ADDRESS_WIDTH(AW), .WIDTH_IN(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r_data_in(r_data_in), .r_valid_in(r_valid_in), .r_sop_in(r_sop_in),
        .r_eop_in(r_eop_in), .r_dest_in(r_dest_in), .r_ready_out(r_ready_out),
        .p_data_out(p_data_out), .p_valid_out(p_valid_out), .p_sop_out(p_sop_out),
        .p_eop_out(p_eop_out), .p_dest_out(p_dest_out), .p_ready_in(p_ready_in),
        .o_locked(o_locked), .o_owner(o_owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] v, input logic [3:0] s,
                           input logic [3:0] e, input logic [W-1:0] d);
        r_valid_in[i*4 +: 4] = v;
        r_sop_in[i*4 +: 4]   = s;
        r_eop_in[i*4 +: 4]   = e;
        r_data_in[i*W +: W]  = d;
        r_dest_in[i*AW +: AW] = AW'(i + 5);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_req(i, 4'b0000, 4'b0000, 4'b0000, W'(0));
    endtask

    // Behavioural model: state describes what the DUT will hold after the next edge.
    logic          m_locked;
    int            m_owner, m_ptr;
    logic [3:0]    m_pv, m_ps, m_pe;
    logic [W-1:0]  m_pd;
    logic [AW-1:0] m_pdst;

    always @(negedge clk) begin
        logic [N-1:0] act;
        logic         load, ok, open;
        int           g, c;
        logic [3:0]   v, s, e;
        if (!rst_n) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = N - 1;
            m_pv = 4'b0000; m_ps = 4'b0000; m_pe = 4'b0000; m_pd = '0; m_pdst = '0;
            chk("rst_ready", 32'(r_ready_out), 32'd0);
            chk("rst_pvalid", 32'(p_valid_out), 32'd0);
            chk("rst_psop", 32'(p_sop_out), 32'd0);
            chk("rst_peop", 32'(p_eop_out), 32'd0);
            chk("rst_pdata", 32'(p_data_out), 32'd0);
            chk("rst_pdest", 32'(p_dest_out), 32'd0);
            chk("rst_locked", 32'(o_locked), 32'd0);
            chk("rst_owner", 32'(o_owner), 32'd0);
        end else begin
            chk("m_locked", 32'(o_locked), 32'(m_locked));
            chk("m_owner", 32'(o_owner), 32'(m_owner));
            chk("m_pvalid", 32'(p_valid_out), 32'(m_pv));
            if (m_pv != 4'b0000) begin
                chk("m_psop", 32'(p_sop_out), 32'(m_ps));
                chk("m_peop", 32'(p_eop_out), 32'(m_pe));
                chk("m_pdata", 32'(p_data_out), 32'(m_pd));
                chk("m_pdest", 32'(p_dest_out), 32'(m_pdst));
            end
            for (int i = 0; i < N; i++) act[i] = (r_valid_in[i*4 +: 4] != 4'b0000);
            load = (m_pv == 4'b0000) || p_ready_in;
            g = 0; ok = 1'b0;
            if (m_locked) begin
                g = m_owner; ok = act[g];
            end else begin
                for (int j = 1; j <= N; j++) begin
                    c = (m_ptr + j) % N;
                    if (!ok && act[c]) begin g = c; ok = 1'b1; end
                end
            end
            chk("m_ready", 32'(r_ready_out), (load && ok) ? (32'd1 << g) : 32'd0);
            if (load && ok) begin
                v = r_valid_in[g*4 +: 4]; s = r_sop_in[g*4 +: 4]; e = r_eop_in[g*4 +: 4];
                open = m_locked;
                for (int k = 0; k < 4; k++) begin
                    if (v[3-k] && s[3-k]) open = 1'b1;
                    if (v[3-k] && e[3-k]) open = 1'b0;
                end
                m_pv = v; m_ps = s; m_pe = e;
                m_pd = r_data_in[g*W +: W]; m_pdst = r_dest_in[g*AW +: AW];
                m_owner = g; m_locked = open;
                if (!open) m_ptr = g;
            end else if (load) begin
                m_pv = 4'b0000;
            end
        end
    end

    initial begin
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
        rst_n = 1'b0; p_ready_in = 1'b1;
        r_data_in = '0; r_valid_in = '0; r_sop_in = '0; r_eop_in = '0; r_dest_in = '0;
        for (int i = 0; i < N; i++) set_req(i, 4'b1111, 4'b1000, 4'b0001, W'(16 * i + 1));
        repeat (2) tick();
        #1;
        chk("reset_ready", 32'(r_ready_out), 32'd0);
        chk("reset_locked", 32'(o_locked), 32'd0);
        chk("reset_pvalid", 32'(p_valid_out), 32'd0);

        // Single-word packets from all requesters: grants 0,1,2,3,0.
        tick(); rst_n = 1'b1; #1;
        chk("rr_first", 32'(r_ready_out), 32'b0001);
        for (int n = 0; n < 4; n++) begin
            tick(); #1;
            chk("rr_seq", 32'(r_ready_out), 32'(exp_seq[n]));
            chk("rr_unlocked", 32'(o_locked), 32'd0);
        end

        // Three-word packet from requester 1 while requester 2 waits.
        tick(); clear_all();
        set_req(1, 4'b1111, 4'b0001, 4'b0000, 12'h111);
        set_req(2, 4'b1111, 4'b1000, 4'b0001, 12'h222);
        #1; chk("pk3_w1", 32'(r_ready_out), 32'b0010); chk("pk3_l0", 32'(o_locked), 32'd0);
        tick(); set_req(1, 4'b1111, 4'b0000, 4'b0000, 12'h112);
        #1; chk("pk3_w2", 32'(r_ready_out), 32'b0010); chk("pk3_l1", 32'(o_locked), 32'd1);
        tick(); set_req(1, 4'b1111, 4'b0000, 4'b1000, 12'h113);
        #1; chk("pk3_w3", 32'(r_ready_out), 32'b0010); chk("pk3_l2", 32'(o_locked), 32'd1);
        tick(); set_req(1, 4'b0000, 4'b0000, 4'b0000, 12'h000);
        #1; chk("pk3_r2", 32'(r_ready_out), 32'b0100); chk("pk3_l3", 32'(o_locked), 32'd0);

        // Locked to requester 0 while it goes idle and requester 3 waits.
        tick(); clear_all();
        set_req(0, 4'b1111, 4'b1000, 4'b0000, 12'h0A0);
        #1; chk("lk_grant0", 32'(r_ready_out), 32'b0001);
        tick();
        set_req(0, 4'b0000, 4'b0000, 4'b0000, 12'h000);
        set_req(3, 4'b1111, 4'b1000, 4'b0001, 12'hA53);
        repeat (5) begin
            #1; chk("lk_hold", 32'(r_ready_out), 32'b0000); chk("lk_locked", 32'(o_locked), 32'd1);
            tick();
        end
        set_req(0, 4'b1111, 4'b0000, 4'b0001, 12'h0A1);
        #1; chk("lk_resume", 32'(r_ready_out), 32'b0001);
        tick(); set_req(0, 4'b0000, 4'b0000, 4'b0000, 12'h000);
        #1; chk("lk_r3", 32'(r_ready_out), 32'b1000);

        // Back-pressure with a pending word.
        tick(); p_ready_in = 1'b0; set_req(3, 4'b1111, 4'b1000, 4'b0001, 12'h3C3);
        repeat (3) begin
            tick(); #1;
            chk("bp_ready", 32'(r_ready_out), 32'b0000);
            chk("bp_data", 32'(p_data_out), 32'hA53);
            chk("bp_valid", 32'(p_valid_out), 32'b1111);
        end
        p_ready_in = 1'b1;
        #1; chk("bp_release", 32'(r_ready_out), 32'b1000);
        tick(); set_req(3, 4'b0000, 4'b0000, 4'b0000, 12'h000);
        #1; chk("bp_next", 32'(p_data_out), 32'h3C3);

        // Reopen inside one word, then close on the next.
        set_req(1, 4'b1111, 4'b0101, 4'b0010, 12'h161);
        #1; chk("ro_grant", 32'(r_ready_out), 32'b0010);
        tick(); set_req(1, 4'b1111, 4'b0000, 4'b0001, 12'h162);
        #1; chk("ro_locked", 32'(o_locked), 32'd1); chk("ro_owner", 32'(o_owner), 32'd1);
        chk("ro_ready", 32'(r_ready_out), 32'b0010);
        tick(); clear_all();
        set_req(0, 4'b1111, 4'b1000, 4'b0001, 12'h0B0);
        set_req(2, 4'b1111, 4'b1000, 4'b0000, 12'h2B0);
        #1; chk("ro_idle", 32'(o_locked), 32'd0); chk("ro_ptr", 32'(r_ready_out), 32'b0100);

        // Reset while locked to requester 2.
        tick(); clear_all();
        #1; chk("rl_locked", 32'(o_locked), 32'd1); chk("rl_owner", 32'(o_owner), 32'd2);
        rst_n = 1'b0;
        #1; chk("rl_pvalid", 32'(p_valid_out), 32'd0); chk("rl_unlock", 32'(o_locked), 32'd0);
        @(negedge clk);
        tick(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'b1111, 4'b1000, 4'b0001, W'(i + 7));
        #1; chk("rl_first", 32'(r_ready_out), 32'b0001);

        // Random traffic, back-pressure and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                set_req(i, ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom_range(1, 15)),
                        ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                        ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                        W'($urandom));
            end
            p_ready_in = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        tick(); rst_n = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
